// File: rtl/tflite_buf_pkg.sv
// tflite_buf_pkg: shared sizing, FSM states and read-word record for the camera-to-NPU image buffer sequencer
package tflite_buf_pkg;
  localparam int IMG_BYTES_DEF = 9216;
  localparam int WORDS_PER_FRAME = IMG_BYTES_DEF / 4;
  localparam int ADA_W = 14;
  localparam int ADB_W = 12;
  typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} state_t;
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } rd_word_t;
endpackage

// File: rtl/tflite_rd_skid.sv
// tflite_rd_skid: 2-entry fall-through FIFO of buffer read words (push/din in; valid/head/count out, popped by ready)
module tflite_rd_skid import tflite_buf_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  rd_word_t   din,
  input  logic       ready,
  output logic       valid,
  output rd_word_t   head,
  output logic [1:0] count
);
  rd_word_t mem [2];
  logic wr_idx, rd_idx, store, take;
  always_comb begin
    valid = push || count != 2'd0;
    head = count != 2'd0 ? mem[rd_idx] : din;
    take = ready && count != 2'd0;
    store = push && !(ready && count == 2'd0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
    end else begin
      count <= count + {1'b0, store} - {1'b0, take};
      if (store) wr_idx <= !wr_idx;
      if (take) rd_idx <= !rd_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (store) mem[wr_idx] <= din;
  end
endmodule

// File: rtl/tflite_img_buf_ctrl.sv
// tflite_img_buf_ctrl: captures one camera frame into the image buffer, then streams it to the NPU as 32-bit valid/ready words (ports: camera in, buffer write/read ports, npu handshake, frame_ready/frame_drop status)
module tflite_img_buf_ctrl #(
  parameter int IMG_BYTES = tflite_buf_pkg::IMG_BYTES_DEF,
  parameter int ADA_W = tflite_buf_pkg::ADA_W,
  parameter int ADB_W = tflite_buf_pkg::ADB_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cam_sof,
  input  logic             cam_valid,
  input  logic [7:0]       cam_data,
  output logic             buf_cea,
  output logic [ADA_W-1:0] buf_ada,
  output logic [7:0]       buf_din,
  output logic             buf_ceb,
  output logic [ADB_W-1:0] buf_adb,
  input  logic [31:0]      buf_dout,
  output logic             frame_ready,
  input  logic             npu_start,
  output logic             npu_valid,
  input  logic             npu_ready,
  output logic [31:0]      npu_data,
  output logic             npu_last,
  output logic             frame_drop
);
  import tflite_buf_pkg::*;
  localparam logic [ADA_W:0] LAST_BYTE = (ADA_W+1)'(IMG_BYTES - 1);
  localparam logic [ADB_W:0] WORDS = (ADB_W+1)'(IMG_BYTES / 4);
  localparam logic [ADB_W:0] LAST_WORD = (ADB_W+1)'(IMG_BYTES / 4 - 1);
  state_t state, state_n;
  logic [ADA_W:0] wr_ptr;
  logic [ADB_W:0] rd_ptr;
  logic in_flight, in_flight_last, fill_sof, fifo_valid;
  logic [1:0] fifo_count;
  rd_word_t pushed, head;
  always_comb begin
    fill_sof = state == FILL && cam_sof;
    buf_cea = state == FILL && cam_valid;
    buf_ada = buf_cea && !fill_sof ? wr_ptr[ADA_W-1:0] : '0;
    buf_din = buf_cea ? cam_data : '0;
    buf_ceb = state == DRAIN && rd_ptr < WORDS && {1'b0, in_flight} + fifo_count < 2'd2;
    buf_adb = buf_ceb ? rd_ptr[ADB_W-1:0] : '0;
    frame_ready = state == READY;
    frame_drop = cam_sof && (state == READY || state == DRAIN);
    pushed = '{last: in_flight_last, data: buf_dout};
    npu_valid = fifo_valid;
    npu_data = fifo_valid ? head.data : '0;
    npu_last = fifo_valid && head.last;
    state_n = state == IDLE && cam_sof ? FILL :
              state == FILL && buf_cea && !fill_sof && wr_ptr == LAST_BYTE ? READY :
              state == READY && npu_start ? DRAIN :
              state == DRAIN && npu_last && npu_ready ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      in_flight <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      state <= state_n;
      in_flight <= buf_ceb;
      in_flight_last <= buf_ceb && rd_ptr == LAST_WORD;
      wr_ptr <= state == IDLE ? '0 : fill_sof ? (ADA_W+1)'(cam_valid) : buf_cea ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= state == READY ? '0 : buf_ceb ? rd_ptr + 1'b1 : rd_ptr;
    end
  end
  tflite_rd_skid skid (
    .clk(clk),
    .reset(reset),
    .push(in_flight),
    .din(pushed),
    .ready(npu_ready),
    .valid(fifo_valid),
    .head(head),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_tflite_img_buf_ctrl.sv
// tb_tflite_img_buf_ctrl: table-driven and scoreboard checks of the image buffer sequencer (16-byte and full-size frames)
module tb_tflite_img_buf_ctrl;
  localparam int SB = 16;
  localparam int BB = 9216;
  typedef struct packed {
    logic        l;
    logic [31:0] d;
  } exp_t;
  typedef struct {
    logic [7:0]  base;
    int          resync_at;
    int          gap;
    int          stall;
    bit          drop_ready;
    bit          drop_drain;
    logic [31:0] exp_w0;
    int          exp_drops;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic sof, cv, st, rdy, cea, ceb, fr, nv, nl, fd;
  logic [7:0] cd, din;
  logic [13:0] ada;
  logic [11:0] adb;
  logic [31:0] dout, nd;
  logic sof2, cv2, st2, rdy2, cea2, ceb2, fr2, nv2, nl2, fd2;
  logic [7:0] cd2, din2;
  logic [13:0] ada2;
  logic [11:0] adb2;
  logic [31:0] dout2, nd2;
  tflite_img_buf_ctrl #(.IMG_BYTES(SB)) dut (
    .clk(clk), .reset(reset), .cam_sof(sof), .cam_valid(cv), .cam_data(cd),
    .buf_cea(cea), .buf_ada(ada), .buf_din(din), .buf_ceb(ceb), .buf_adb(adb), .buf_dout(dout),
    .frame_ready(fr), .npu_start(st), .npu_valid(nv), .npu_ready(rdy), .npu_data(nd),
    .npu_last(nl), .frame_drop(fd)
  );
  tflite_img_buf_ctrl dut_big (
    .clk(clk), .reset(reset), .cam_sof(sof2), .cam_valid(cv2), .cam_data(cd2),
    .buf_cea(cea2), .buf_ada(ada2), .buf_din(din2), .buf_ceb(ceb2), .buf_adb(adb2), .buf_dout(dout2),
    .frame_ready(fr2), .npu_start(st2), .npu_valid(nv2), .npu_ready(rdy2), .npu_data(nd2),
    .npu_last(nl2), .frame_drop(fd2)
  );
  bit [7:0] m1 [SB];
  bit [7:0] m2 [BB];
  always @(posedge clk) begin
    if (cea && int'(ada) < SB) m1[int'(ada)] <= din;
    if (ceb && int'(adb) < SB / 4)
      dout <= {m1[4*int'(adb)+3], m1[4*int'(adb)+2], m1[4*int'(adb)+1], m1[4*int'(adb)]};
    if (cea2 && int'(ada2) < BB) m2[int'(ada2)] <= din2;
    if (ceb2 && int'(adb2) < BB / 4)
      dout2 <= {m2[4*int'(adb2)+3], m2[4*int'(adb2)+2], m2[4*int'(adb2)+1], m2[4*int'(adb2)]};
  end
  int errs = 0, checks = 0;
  int cyc = 0, xf = 0, fv = -1, out = 0, max_out = 0, drops = 0, bad_cea = 0;
  int xf2 = 0, nlast2 = 0, last_adb2 = -1;
  bit lock = 0;
  logic [31:0] w0;
  exp_t q1 [$];
  exp_t q2 [$];
  vec_t vecs [5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic observe();
    exp_t e;
    cyc++;
    if (lock && cea) bad_cea++;
    if (fd) drops++;
    if (ceb) begin
      out++;
      if (out > max_out) max_out = out;
    end
    if (nv && fv < 0) fv = cyc;
    if (nv) begin
      if (q1.size() == 0) chk("sb_unexpected_valid", 32'd1, 32'd0);
      else begin
        chk("sb_data", nd, q1[0].d);
        if (rdy) begin
          e = q1.pop_front();
          chk("sb_last", 32'(nl), 32'(e.l));
          if (xf == 0) w0 = nd;
          xf++;
          out--;
        end
      end
    end
    if (ceb2) last_adb2 = int'(adb2);
    if (nv2 && rdy2) begin
      if (q2.size() == 0) chk("sb2_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("sb2_data", nd2, e.d);
        chk("sb2_last", 32'(nl2), 32'(e.l));
      end
      xf2++;
      if (nl2) nlast2++;
    end
  endtask
  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [7:0] base, input int resync_at, input int gap);
    logic [7:0] fb [SB];
    int n = 0;
    sof = 1'b1;
    step();
    sof = 1'b0;
    for (int i = 0; n < SB; i++) begin
      sof = i == resync_at;
      if (sof) n = 0;
      cv = 1'b1;
      cd = (resync_at >= 0 && i >= resync_at) ? 8'hAA + 8'(i - resync_at) : base + 8'(i);
      fb[n] = cd;
      n++;
      if (n == SB) chk("frame_ready_early", 32'(fr), 32'd0);
      step();
      if (gap > 0) begin
        cv = 1'b0;
        sof = 1'b0;
        repeat ($urandom_range(0, gap)) step();
      end
    end
    cv = 1'b0;
    sof = 1'b0;
    chk("frame_ready_after_fill", 32'(fr), 32'd1);
    for (int w = 0; w < SB / 4; w++)
      q1.push_back('{l: w == SB / 4 - 1, d: {fb[4*w+3], fb[4*w+2], fb[4*w+1], fb[4*w]}});
  endtask
  task automatic drain(input int stall, input bit drop_ready, input bit drop_drain,
                       input logic [31:0] exp_w0, input int exp_drops);
    int start;
    lock = 1;
    xf = 0; fv = -1; w0 = '0; out = 0; max_out = 0; drops = 0; bad_cea = 0;
    cv = 1'b1;
    cd = 8'hEE;
    sof = drop_ready;
    step();
    cv = 1'b0;
    sof = 1'b0;
    chk("frame_ready_hold", 32'(fr), 32'd1);
    st = 1'b1;
    rdy = stall == 0;
    start = cyc + 1;
    step();
    st = 1'b0;
    chk("frame_ready_drop", 32'(fr), 32'd0);
    for (int k = 0; k < 400 && xf < SB / 4; k++) begin
      rdy = stall == 0 ? 1'b1 : stall == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      sof = drop_drain && k == 0;
      step();
      sof = 1'b0;
    end
    rdy = 1'b0;
    lock = 0;
    chk("transfers", 32'(xf), 32'(SB / 4));
    chk("queue_empty", 32'(q1.size()), 32'd0);
    chk("first_word", w0, exp_w0);
    chk("first_valid_latency", 32'(fv - start), 32'd2);
    chk("frame_drops", 32'(drops), 32'(exp_drops));
    chk("no_write_when_locked", 32'(bad_cea), 32'd0);
    chk("outstanding_le2", 32'(max_out <= 2), 32'd1);
    chk("idle_after_drain", {30'd0, fr, nv}, 32'd0);
  endtask
  task automatic run_vec(input vec_t v);
    fill(v.base, v.resync_at, v.gap);
    drain(v.stall, v.drop_ready, v.drop_drain, v.exp_w0, v.exp_drops);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] wb;
    vecs[0] = '{8'h00, -1, 0, 0, 1'b0, 1'b0, 32'h03020100, 0};
    vecs[1] = '{8'h00, -1, 0, 1, 1'b0, 1'b0, 32'h03020100, 0};
    vecs[2] = '{8'h40, 6, 0, 0, 1'b0, 1'b0, 32'hADACABAA, 0};
    vecs[3] = '{8'h20, -1, 0, 0, 1'b1, 1'b1, 32'h23222120, 2};
    vecs[4] = '{8'h80, -1, 2, 2, 1'b0, 1'b0, 32'h83828180, 0};
    reset = 1'b1;
    {sof, cv, st, rdy, sof2, cv2, st2, rdy2} = '0;
    cd = '0;
    cd2 = '0;
    @(posedge clk);
    #1;
    step();
    chk("reset_outputs", {22'd0, cea, ceb, fr, nv, nl, fd, 4'd0}, 32'd0);
    chk("reset_addrs", {6'd0, ada, adb}, 32'd0);
    chk("reset_data", nd, 32'd0);
    reset = 1'b0;
    cv = 1'b1;
    cd = 8'h33;
    #1;
    chk("idle_ignores_valid", 32'(cea), 32'd0);
    step();
    cv = 1'b0;
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    fill(8'h50, -1, 0);
    lock = 1;
    xf = 0;
    rdy = 1'b1;
    st = 1'b1;
    step();
    st = 1'b0;
    for (int k = 0; k < 20 && xf < 2; k++) step();
    rdy = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    lock = 0;
    chk("xfers_before_reset", 32'(xf), 32'd2);
    chk("reset_mid_drain_valid", 32'(nv), 32'd0);
    chk("reset_mid_drain_ready", 32'(fr), 32'd0);
    q1.delete();
    cv = 1'b1;
    cd = 8'h77;
    #1;
    chk("idle_after_reset", 32'(cea), 32'd0);
    cv = 1'b0;
    st = 1'b1;
    step();
    st = 1'b0;
    step();
    chk("start_in_idle_ignored", {30'd0, fr, nv}, 32'd0);
    run_vec('{8'h60, -1, 0, 0, 1'b0, 1'b0, 32'h63626160, 0});
    sof2 = 1'b1;
    step();
    sof2 = 1'b0;
    wb = '0;
    for (int i = 0; i < BB; ) begin
      cv2 = $urandom_range(0, 3) != 0;
      cd2 = 8'($urandom);
      if (cv2) begin
        wb[8*(i%4) +: 8] = cd2;
        if (i % 4 == 3) q2.push_back('{l: i == BB - 1, d: wb});
        i++;
      end
      step();
    end
    cv2 = 1'b0;
    chk("big_frame_ready", 32'(fr2), 32'd1);
    st2 = 1'b1;
    step();
    st2 = 1'b0;
    for (int k = 0; k < 20000 && xf2 < BB / 4; k++) begin
      rdy2 = $urandom_range(0, 3) != 0;
      step();
    end
    rdy2 = 1'b0;
    chk("big_transfers", 32'(xf2), 32'(BB / 4));
    chk("big_last_adb", 32'(last_adb2), 32'(BB / 4 - 1));
    chk("big_last_count", 32'(nlast2), 32'd1);
    chk("big_queue_empty", 32'(q2.size()), 32'd0);
    chk("big_idle", {30'd0, fr2, nv2}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
